// File: rtl/pipelined_reduction_gate.sv
// Pipelined N-input reduction gate: run-time bubble mask, AND/OR/XOR/THRESHOLD
// reduction with optional inversion, behind a two-stage valid/ready pipeline.
module pipelined_reduction_gate #(
   parameter int unsigned NrOfInputs  = 7,
   parameter logic [31:0] BubblesMask = 32'h1,
   parameter int unsigned Threshold   = 4
) (
   input  logic                  GlobalClock,
   input  logic                  Reset_n,
   input  logic [NrOfInputs-1:0] In_Data,
   input  logic [1:0]            In_Mode,
   input  logic                  In_Invert,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   input  logic                  Mask_Load,
   input  logic [NrOfInputs-1:0] Mask_Data,
   output logic [NrOfInputs-1:0] Mask,
   output logic                  Result,
   output logic [5:0]            Ones_Count,
   output logic                  Out_Valid,
   input  logic                  Out_Ready
);

   typedef enum logic [1:0] {
      ModeAnd = 2'd0,
      ModeOr  = 2'd1,
      ModeXor = 2'd2,
      ModeThr = 2'd3
   } mode_e;

   localparam logic [NrOfInputs-1:0] MaskReset = BubblesMask[NrOfInputs-1:0];
   localparam logic [5:0]            AllOnes   = 6'(NrOfInputs);
   localparam logic [5:0]            ThrCount  = 6'(Threshold);

   logic [NrOfInputs-1:0] mask_q, mask_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [NrOfInputs-1:0] s1_vec_q, s1_vec_d;
   mode_e                 s1_mode_q, s1_mode_d;
   logic                  s1_inv_q, s1_inv_d;
   logic                  s2_valid_q, s2_valid_d;
   logic                  result_q, result_d;
   logic [5:0]            count_q, count_d;

   logic                  s2_adv;
   logic [5:0]            pop;
   logic                  reduced;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < NrOfInputs; i++) begin
         pop = pop + 6'(s1_vec_q[i]);
      end
      unique case (s1_mode_q)
         ModeAnd: reduced = (pop == AllOnes);
         ModeOr:  reduced = (pop != '0);
         ModeXor: reduced = pop[0];
         default: reduced = (pop >= ThrCount);
      endcase
   end

   // Stage 1 may refill in the same cycle stage 2 drains, keeping one item per cycle.
   always_comb begin
      s2_adv     = !s2_valid_q || Out_Ready;
      In_Ready   = !s1_valid_q || s2_adv;

      mask_d     = mask_q;
      s1_valid_d = s1_valid_q;
      s1_vec_d   = s1_vec_q;
      s1_mode_d  = s1_mode_q;
      s1_inv_d   = s1_inv_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      count_d    = count_q;

      if (Mask_Load) begin
         mask_d = Mask_Data;
      end
      if (In_Ready) begin
         s1_valid_d = In_Valid;
         if (In_Valid) begin
            s1_vec_d  = In_Data ^ mask_q;
            s1_mode_d = mode_e'(In_Mode);
            s1_inv_d  = In_Invert;
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = reduced ^ s1_inv_q;
            count_d  = pop;
         end
      end
   end

   always_ff @(posedge GlobalClock or negedge Reset_n) begin
      if (!Reset_n) begin
         mask_q     <= MaskReset;
         s1_valid_q <= 1'b0;
         s1_vec_q   <= '0;
         s1_mode_q  <= ModeAnd;
         s1_inv_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         result_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         mask_q     <= mask_d;
         s1_valid_q <= s1_valid_d;
         s1_vec_q   <= s1_vec_d;
         s1_mode_q  <= s1_mode_d;
         s1_inv_q   <= s1_inv_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         count_q    <= count_d;
      end
   end

   assign Mask       = mask_q;
   assign Result     = result_q;
   assign Ones_Count = count_q;
   assign Out_Valid  = s2_valid_q;

endmodule

// File: tb/tb_pipelined_reduction_gate.sv
// Bench for pipelined_reduction_gate: directed scenarios on a 7-input gate plus
// randomized traffic on 7-, 2- and 32-input gates against a popcount model.
module tb_pipelined_reduction_gate;

   localparam int unsigned NW [3] = '{7, 2, 32};
   localparam int unsigned TH [3] = '{4, 2, 17};
   localparam logic [31:0] RM [3] = '{32'h1, 32'h2, 32'hA5A5_0F0F};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data [3];
   logic [31:0] mask_data [3];
   logic [31:0] mask_o [3];
   logic [1:0]  in_mode [3];
   logic        in_inv [3], in_valid [3], in_ready [3], mask_load [3];
   logic        result [3], out_valid [3], out_ready [3];
   logic [5:0]  ones [3];
   logic [6:0]  m0;
   logic [1:0]  m1;
   logic [31:0] m2;

   int unsigned total = 0;
   int unsigned bad = 0;
   logic [6:0]  sb [3][64];
   int unsigned wr [3], rd [3];
   logic [31:0] mmask [3];

   logic [1:0]  md_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
   logic        iv_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        ex_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [31:0] bp_tab [5] = '{32'h01, 32'h03, 32'h07, 32'h0F, 32'h1F};

   always #5 clk = ~clk;

   assign mask_o[0] = {25'd0, m0};
   assign mask_o[1] = {30'd0, m1};
   assign mask_o[2] = m2;

   pipelined_reduction_gate #(.NrOfInputs(7), .BubblesMask(32'h1), .Threshold(4)) u_dut7 (
      .GlobalClock(clk), .Reset_n(rst_n), .In_Data(in_data[0][6:0]), .In_Mode(in_mode[0]),
      .In_Invert(in_inv[0]), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
      .Mask_Load(mask_load[0]), .Mask_Data(mask_data[0][6:0]), .Mask(m0), .Result(result[0]),
      .Ones_Count(ones[0]), .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]));

   pipelined_reduction_gate #(.NrOfInputs(2), .BubblesMask(32'h2), .Threshold(2)) u_dut2 (
      .GlobalClock(clk), .Reset_n(rst_n), .In_Data(in_data[1][1:0]), .In_Mode(in_mode[1]),
      .In_Invert(in_inv[1]), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
      .Mask_Load(mask_load[1]), .Mask_Data(mask_data[1][1:0]), .Mask(m1), .Result(result[1]),
      .Ones_Count(ones[1]), .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]));

   pipelined_reduction_gate #(.NrOfInputs(32), .BubblesMask(32'hA5A5_0F0F), .Threshold(17)) u_dut32 (
      .GlobalClock(clk), .Reset_n(rst_n), .In_Data(in_data[2]), .In_Mode(in_mode[2]),
      .In_Invert(in_inv[2]), .In_Valid(in_valid[2]), .In_Ready(in_ready[2]),
      .Mask_Load(mask_load[2]), .Mask_Data(mask_data[2]), .Mask(m2), .Result(result[2]),
      .Ones_Count(ones[2]), .Out_Valid(out_valid[2]), .Out_Ready(out_ready[2]));

   function automatic logic [31:0] wmask(input int unsigned n);
      logic [31:0] m;
      m = '1;
      return (n >= 32) ? m : (m >> (32 - n));
   endfunction

   // Returns {result, ones_count} for an already-bubbled input vector.
   function automatic logic [6:0] model(input logic [31:0] v, input int unsigned n,
                                        input int unsigned thr, input logic [1:0] mode,
                                        input logic inv);
      int unsigned c;
      logic        r;
      c = 0;
      for (int unsigned i = 0; i < n; i++) if (v[i]) c++;
      case (mode)
         2'd0:    r = (c == n);
         2'd1:    r = (c != 0);
         2'd2:    r = ((c % 2) == 1);
         default: r = (c >= thr);
      endcase
      return {r ^ inv, c[5:0]};
   endfunction

   task automatic init_inputs();
      for (int unsigned k = 0; k < 3; k++) begin
         in_data[k] = '0; mask_data[k] = '0; in_mode[k] = '0; in_inv[k] = 1'b0;
         in_valid[k] = 1'b0; mask_load[k] = 1'b0; out_ready[k] = 1'b1;
         wr[k] = 0; rd[k] = 0; mmask[k] = RM[k] & wmask(NW[k]);
      end
   endtask

   task automatic tick();
      #1;
      for (int unsigned k = 0; k < 3; k++) begin
         if (in_valid[k] && in_ready[k]) begin
            sb[k][wr[k] % 64] = model((in_data[k] ^ mmask[k]) & wmask(NW[k]), NW[k], TH[k],
                                      in_mode[k], in_inv[k]);
            wr[k]++;
         end
         if (mask_load[k]) mmask[k] = mask_data[k] & wmask(NW[k]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      init_inputs();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_inputs();
      #7;
      total++; if (m0 !== 7'h01) begin bad++; $display("FAIL reset_mask7 got=%h exp=%h", m0, 7'h01); end
      total++; if (m1 !== 2'b10) begin bad++; $display("FAIL reset_mask2 got=%b exp=%b", m1, 2'b10); end
      total++; if (m2 !== 32'hA5A5_0F0F) begin bad++; $display("FAIL reset_mask32 got=%h exp=%h", m2, 32'hA5A5_0F0F); end
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid[0]); end
      total++; if ({result[0], ones[0]} !== 7'd0) begin bad++; $display("FAIL reset_result got=%b/%0d exp=0/0", result[0], ones[0]); end
      total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready[0]); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      total++; if (m0 !== 7'h01 || out_valid[0] !== 1'b0) begin bad++; $display("FAIL post_reset got=%h/%b exp=01/0", m0, out_valid[0]); end
   endtask

   task automatic test_default_and();
      in_data[0] = 32'b1111110; in_mode[0] = 2'd0; in_inv[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      tick();
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL and_latency got=%b exp=0", out_valid[0]); end
      in_data[0] = 32'h7F;
      tick();
      in_valid[0] = 1'b0;
      total++; if ({out_valid[0], result[0], ones[0]} !== {1'b1, 1'b1, 6'd7}) begin bad++; $display("FAIL and_all_ones got=%b/%b/%0d exp=1/1/7", out_valid[0], result[0], ones[0]); end
      tick();
      total++; if ({out_valid[0], result[0], ones[0]} !== {1'b1, 1'b0, 6'd6}) begin bad++; $display("FAIL and_bubbled got=%b/%b/%0d exp=1/0/6", out_valid[0], result[0], ones[0]); end
      tick();
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL and_drained got=%b exp=0", out_valid[0]); end
   endtask

   task automatic test_modes();
      mask_load[0] = 1'b1; mask_data[0] = '0;
      tick();
      mask_load[0] = 1'b0;
      total++; if (m0 !== 7'h00) begin bad++; $display("FAIL mode_mask_load got=%h exp=00", m0); end
      for (int unsigned t = 0; t < 5; t++) begin
         in_data[0] = 32'b0010110; in_mode[0] = md_tab[t]; in_inv[0] = iv_tab[t]; in_valid[0] = 1'b1;
         tick();
         in_valid[0] = 1'b0;
         tick();
         total++;
         if ({out_valid[0], result[0], ones[0]} !== {1'b1, ex_tab[t], 6'd3}) begin
            bad++; $display("FAIL mode_%0d got=%b/%b/%0d exp=1/%b/3", t, out_valid[0], result[0], ones[0], ex_tab[t]);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      int unsigned sent, got, cyc;
      sent = 0;
      out_ready[0] = 1'b0; in_mode[0] = 2'd3; in_inv[0] = 1'b0;
      for (int unsigned c = 0; c < 6; c++) begin
         in_valid[0] = 1'b1; in_data[0] = bp_tab[sent];
         #1;
         if (in_ready[0]) sent++;
         tick();
      end
      total++; if (sent != 2 || in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_stall got=%0d/%b exp=2/0", sent, in_ready[0]); end
      for (int unsigned c = 0; c < 2; c++) begin
         total++;
         if ({out_valid[0], result[0], ones[0]} !== {1'b1, 1'b0, 6'd1}) begin
            bad++; $display("FAIL bp_hold got=%b/%b/%0d exp=1/0/1", out_valid[0], result[0], ones[0]);
         end
         tick();
      end
      out_ready[0] = 1'b1; got = 0; cyc = 0;
      while (got < 5 && cyc < 20) begin
         in_valid[0] = (sent < 5);
         if (sent < 5) in_data[0] = bp_tab[sent];
         #1;
         if (out_valid[0]) begin
            total++;
            if ({result[0], ones[0]} !== {(got >= 3), 6'(got + 1)}) begin
               bad++; $display("FAIL bp_order_%0d got=%b/%0d exp=%b/%0d", got, result[0], ones[0], (got >= 3), got + 1);
            end
            got++;
         end
         if (in_valid[0] && in_ready[0]) sent++;
         tick();
         cyc++;
      end
      in_valid[0] = 1'b0;
      total++; if (got != 5 || cyc != 5) begin bad++; $display("FAIL bp_drain got=%0d items/%0d cycles exp=5/5", got, cyc); end
   endtask

   task automatic test_mask_timing();
      apply_reset();
      mask_load[0] = 1'b1; mask_data[0] = 32'h7F;
      in_data[0] = '0; in_mode[0] = 2'd0; in_inv[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      tick();
      mask_load[0] = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      total++; if (m0 !== 7'h7F) begin bad++; $display("FAIL mask_new got=%h exp=7f", m0); end
      total++; if ({out_valid[0], result[0], ones[0]} !== {1'b1, 1'b0, 6'd1}) begin bad++; $display("FAIL mask_old_used got=%b/%b/%0d exp=1/0/1", out_valid[0], result[0], ones[0]); end
      tick();
      total++; if ({out_valid[0], result[0], ones[0]} !== {1'b1, 1'b1, 6'd7}) begin bad++; $display("FAIL mask_new_used got=%b/%b/%0d exp=1/1/7", out_valid[0], result[0], ones[0]); end
      tick();
   endtask

   task automatic test_async_reset();
      apply_reset();
      mask_load[0] = 1'b1; mask_data[0] = 32'h55;
      out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 32'h7F; in_mode[0] = 2'd1;
      tick();
      mask_load[0] = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      total++; if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || m0 !== 7'h55) begin bad++; $display("FAIL ar_full got=%b/%b/%h exp=1/0/55", out_valid[0], in_ready[0], m0); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid[0]); end
      total++; if (m0 !== 7'h01) begin bad++; $display("FAIL ar_mask got=%h exp=01", m0); end
      total++; if ({result[0], ones[0], in_ready[0]} !== {1'b0, 6'd0, 1'b1}) begin bad++; $display("FAIL ar_regs got=%b/%0d/%b exp=0/0/1", result[0], ones[0], in_ready[0]); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready[0] = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin wr[k] = 0; rd[k] = 0; mmask[k] = RM[k] & wmask(NW[k]); end
      for (int unsigned c = 0; c < 4; c++) begin
         tick();
         total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL ar_stale_%0d got=%b exp=0", c, out_valid[0]); end
      end
   endtask

   task automatic test_random_sweep();
      logic        last_acc [3], hold_v [3], quiet, exp_rdy;
      logic [6:0]  hold_val [3];
      apply_reset();
      for (int unsigned k = 0; k < 3; k++) begin last_acc[k] = 1'b0; hold_v[k] = 1'b0; hold_val[k] = '0; end
      for (int unsigned cyc = 0; cyc < 400; cyc++) begin
         quiet = (cyc >= 380);
         for (int unsigned k = 0; k < 3; k++) begin
            if (!in_valid[k] || last_acc[k]) begin
               in_valid[k] = !quiet && ($urandom_range(3) != 0);
               in_data[k]  = $urandom;
               in_mode[k]  = 2'($urandom_range(3));
               in_inv[k]   = 1'($urandom_range(1));
            end
            out_ready[k] = quiet || ($urandom_range(3) != 0);
            mask_load[k] = ($urandom_range(7) == 0);
            mask_data[k] = $urandom;
         end
         #1;
         for (int unsigned k = 0; k < 3; k++) begin
            if (hold_v[k]) begin
               total++;
               if (out_valid[k] !== 1'b1 || {result[k], ones[k]} !== hold_val[k]) begin
                  bad++; $display("FAIL rnd_hold_w%0d got=%b/%h exp=1/%h", NW[k], out_valid[k], {result[k], ones[k]}, hold_val[k]);
               end
            end
            exp_rdy = ((wr[k] - rd[k]) < 2) || out_ready[k];
            total++; if (in_ready[k] !== exp_rdy) begin bad++; $display("FAIL rnd_ready_w%0d got=%b exp=%b", NW[k], in_ready[k], exp_rdy); end
            total++; if (mask_o[k] !== mmask[k]) begin bad++; $display("FAIL rnd_mask_w%0d got=%h exp=%h", NW[k], mask_o[k], mmask[k]); end
            if (out_valid[k] && out_ready[k]) begin
               total++;
               if (rd[k] == wr[k]) begin
                  bad++; $display("FAIL rnd_spurious_w%0d got=%h exp=none", NW[k], {result[k], ones[k]});
               end else begin
                  if ({result[k], ones[k]} !== sb[k][rd[k] % 64]) begin
                     bad++; $display("FAIL rnd_result_w%0d got=%b/%0d exp=%b/%0d", NW[k], result[k], ones[k], sb[k][rd[k] % 64][6], sb[k][rd[k] % 64][5:0]);
                  end
                  rd[k]++;
               end
            end
            hold_v[k]   = out_valid[k] && !out_ready[k];
            hold_val[k] = {result[k], ones[k]};
            last_acc[k] = in_valid[k] && in_ready[k];
         end
         tick();
      end
      for (int unsigned k = 0; k < 3; k++) begin
         total++; if (rd[k] != wr[k] || wr[k] < 50) begin bad++; $display("FAIL rnd_drain_w%0d got=%0d/%0d exp=all consumed", NW[k], rd[k], wr[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_default_and();
      test_modes();
      test_backpressure();
      test_mask_timing();
      test_async_reset();
      test_random_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
